// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between datapath and memory responder
interface mem_responder_if;
    logic        MARin;
    logic [31:0] BusMuxOut;
    logic        Read;
    logic        Write;
    logic [31:0] mdrData;
    logic [31:0] Mdatain;
    logic        Done;
    logic        Busy;

    modport master (
        output MARin, BusMuxOut, Read, Write, mdrData,
        input  Mdatain, Done, Busy
    );

    modport slave (
        input  MARin, BusMuxOut, Read, Write, mdrData,
        output Mdatain, Done, Busy
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory behind a MAR with read/write handshake
module mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic            Clock,
    input  logic            clear,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, HOLD} state_t;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  mar_q, mar_d;
    logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [31:0]            mdat_q;
    logic                   rd_fire, wr_fire;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Upper bus bits do not participate in addressing; addresses alias modulo depth.
    logic unused_bus_hi;
    assign unused_bus_hi = ^bus.BusMuxOut[31:DEPTH_LOG2];

    always_comb begin
        state_d = state_q;
        mar_d   = bus.MARin ? bus.BusMuxOut[DEPTH_LOG2-1:0] : mar_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Read) begin
                    addr_d  = mar_q;
                    cnt_d   = CNT_INIT;
                    state_d = RD_WAIT;
                end else if (bus.Write) begin
                    addr_d  = mar_q;
                    data_d  = bus.mdrData;
                    cnt_d   = CNT_INIT;
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rd_fire = clear;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_WAIT: begin
                if (cnt_q == 3'd0) begin
                    // Gated by clear so a reset landing on the completion edge aborts the write.
                    wr_fire = clear;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HOLD: begin
                if (!bus.Read && !bus.Write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_q <= IDLE;
            mar_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!clear) begin
            mdat_q <= '0;
        end else if (rd_fire) begin
            mdat_q <= mem[addr_q];
        end
    end

    // Memory array has no reset so its contents survive clear.
    always_ff @(posedge Clock) begin
        if (wr_fire) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.Mdatain = mdat_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder at LATENCY 2, 1 and 7 with a transaction-level model
module tb_mem_responder;
    logic        Clock = 1'b0;
    logic        clear;
    logic        marin, rd, wr;
    logic [31:0] bus_v, mdr;

    logic [31:0] d_mdat [3];
    logic        d_done [3];
    logic        d_busy [3];

    int checks = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
        mem_responder_if u_if ();
        assign u_if.MARin     = marin;
        assign u_if.BusMuxOut = bus_v;
        assign u_if.Read      = rd;
        assign u_if.Write     = wr;
        assign u_if.mdrData   = mdr;
        mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(9)) u_dut (
            .Clock (Clock),
            .clear (clear),
            .bus   (u_if.slave)
        );
        assign d_mdat[g] = u_if.Mdatain;
        assign d_done[g] = u_if.Done;
        assign d_busy[g] = u_if.Busy;
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    // Model: a request accepted on edge n completes on edge n+LAT; afterwards the
    // responder stays busy until an edge sees both request levels low.
    int unsigned cyc = 0;
    logic [8:0]  m_mar   [3];
    logic [31:0] m_mem   [3][512];
    bit          m_known [3][512];
    bit          m_fly [3], m_hold [3], m_rd [3];
    logic [8:0]  m_addr  [3];
    logic [31:0] m_data  [3];
    int unsigned m_acc   [3];
    logic [31:0] e_mdat  [3];
    bit          e_known [3], e_done [3], e_busy [3];

    always @(posedge Clock) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!clear) begin
                m_mar[i] = '0; m_fly[i] = 0; m_hold[i] = 0;
                e_mdat[i] = '0; e_known[i] = 1; e_done[i] = 0;
            end else begin
                e_done[i] = 0;
                if (m_fly[i]) begin
                    if (cyc == m_acc[i] + lat_of(i)) begin
                        if (m_rd[i]) begin
                            e_mdat[i]  = m_mem[i][m_addr[i]];
                            e_known[i] = m_known[i][m_addr[i]];
                        end else begin
                            m_mem[i][m_addr[i]]   = m_data[i];
                            m_known[i][m_addr[i]] = 1;
                        end
                        e_done[i] = 1; m_fly[i] = 0; m_hold[i] = 1;
                    end
                end else if (m_hold[i]) begin
                    if (!rd && !wr) m_hold[i] = 0;
                end else if (rd || wr) begin
                    m_fly[i] = 1; m_rd[i] = rd; m_addr[i] = m_mar[i];
                    m_data[i] = mdr; m_acc[i] = cyc;
                end
                if (marin) m_mar[i] = bus_v[8:0];
            end
            e_busy[i] = m_fly[i] | m_hold[i];
        end
    end

    int unsigned done_cnt [3] = '{0, 0, 0};
    int unsigned done_before [3];
    int unsigned last_done [3] = '{0, 0, 0};
    int unsigned acc_edge;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("Done[L%0d]", lat_of(i)), {31'b0, d_done[i]}, {31'b0, e_done[i]});
            chk($sformatf("Busy[L%0d]", lat_of(i)), {31'b0, d_busy[i]}, {31'b0, e_busy[i]});
            if (e_known[i]) chk($sformatf("Mdatain[L%0d]", lat_of(i)), d_mdat[i], e_mdat[i]);
            if (d_done[i] === 1'b1) begin
                done_cnt[i]++;
                last_done[i] = cyc;
            end
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        compare_all();
    endtask

    task automatic snap();
        acc_edge = cyc + 1;
        for (int i = 0; i < 3; i++) done_before[i] = done_cnt[i];
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((d_busy[0] | d_busy[1] | d_busy[2]) && n < 30) begin
            tick();
            n++;
        end
        chk("idle_within_budget", {31'b0, d_busy[0] | d_busy[1] | d_busy[2]}, 32'd0);
    endtask

    task automatic load_mar(input logic [31:0] a);
        marin = 1'b1; bus_v = a;
        tick();
        marin = 1'b0;
    endtask

    task automatic op(input bit r, input bit w, input logic [31:0] d, input int hold);
        rd = r; wr = w; mdr = d;
        snap();
        repeat (hold) tick();
        rd = 1'b0; wr = 1'b0; mdr = ~d;
        tick();
        wait_idle();
    endtask

    task automatic check_op(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ndone[L%0d]", tag, lat_of(i)), 32'(done_cnt[i] - done_before[i]), 32'd1);
            chk($sformatf("%s_latency[L%0d]", tag, lat_of(i)), 32'(last_done[i] - acc_edge), 32'(lat_of(i)));
        end
    endtask

    task automatic check_mdat(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_mdat[L%0d]", tag, lat_of(i)), d_mdat[i], exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_mdat[L%0d]", tag, lat_of(i)), d_mdat[i], 32'h0);
            chk($sformatf("%s_done[L%0d]", tag, lat_of(i)), {31'b0, d_done[i]}, 32'd0);
            chk($sformatf("%s_busy[L%0d]", tag, lat_of(i)), {31'b0, d_busy[i]}, 32'd0);
        end
    endtask

    initial begin
        clear = 1'b0; marin = 1'b0; rd = 1'b0; wr = 1'b0; bus_v = '0; mdr = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        clear = 1'b1;
        tick();

        // Write then read back at address 5.
        load_mar(32'h0000_0005);
        op(0, 1, 32'hFFFF_FFF4, 1); check_op("wr5");
        op(1, 0, 32'h0, 1);         check_op("rd5"); check_mdat("rd5", 32'hFFFF_FFF4);

        // Aliasing: 0x205 maps onto word 5.
        op(0, 1, 32'h0000_0005, 1); check_op("wr5b");
        load_mar(32'h0000_0205);
        op(1, 0, 32'h0, 1);         check_op("alias"); check_mdat("alias", 32'h0000_0005);

        // MAR reload during an in-flight read only retargets MAR.
        rd = 1'b1; snap(); tick(); rd = 1'b0;
        marin = 1'b1; bus_v = 32'h0000_0020; tick(); marin = 1'b0;
        tick(); wait_idle();
        check_op("midmar"); check_mdat("midmar", 32'h0000_0005);

        // Read and Write together: read wins, memory untouched.
        op(0, 1, 32'hA5A5_0001, 1); check_op("wr20");
        op(1, 1, 32'hDEAD_BEEF, 1); check_op("rdwr"); check_mdat("rdwr", 32'hA5A5_0001);
        op(1, 0, 32'h0, 1);         check_op("rd20"); check_mdat("rd20", 32'hA5A5_0001);

        // A Read edge while busy with a write is dropped.
        load_mar(32'h0000_0030);
        wr = 1'b1; mdr = 32'h0BAD_F00D; snap(); tick();
        wr = 1'b0; rd = 1'b1; tick(); rd = 1'b0; tick(); wait_idle();
        check_op("busyedge"); check_mdat("busyedge", 32'hA5A5_0001);

        // Read held for 6 cycles: one Done, Busy falls the edge after Read drops.
        rd = 1'b1; snap();
        repeat (6) tick();
        rd = 1'b0;
        chk("hold_busy_before_L2", {31'b0, d_busy[0]}, 32'd1);
        tick();
        chk("hold_busy_after_L2", {31'b0, d_busy[0]}, 32'd0);
        wait_idle();
        check_op("held"); check_mdat("held", 32'h0BAD_F00D);

        // Reset during WR_WAIT aborts the write.
        load_mar(32'h0000_0010);
        op(0, 1, 32'h1111_0010, 1); check_op("wr10");
        wr = 1'b1; mdr = 32'h1234_5678; tick();
        wr = 1'b0; clear = 1'b0; tick(); tick();
        check_reset_outputs("abort");
        clear = 1'b1;
        load_mar(32'h0000_0010);
        op(1, 0, 32'h0, 1); check_op("rd10"); check_mdat("rd10", 32'h1111_0010);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
